// File: rtl/bp_fe_ltb_assoc.sv
// bp_fe_ltb_assoc: set-associative loop termination buffer predicting loop-exit branches
// from a learned per-PC trip count, with confidence, round-robin victims and flush-driven re-clear.
module bp_fe_ltb_assoc #(
  parameter int idx_width_p   = 6,
  parameter int ways_p        = 2,
  parameter int tag_width_p   = 10,
  parameter int cnt_width_p   = 8,
  parameter int conf_width_p  = 2,
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  output logic                     init_done_o,
  input  logic                     r_v_i,
  input  logic [vaddr_width_p-1:0] r_addr_i,
  input  logic                     r_retry_i,
  output logic                     pred_v_o,
  output logic                     pred_conf_o,
  output logic                     pred_taken_o,
  input  logic                     w_v_i,
  input  logic [vaddr_width_p-1:0] br_src_addr_i,
  input  logic                     br_taken_i,
  input  logic                     br_mispredict_i,
  output logic                     w_yumi_o
);
  localparam int sets_lp = 2**idx_width_p;
  localparam int way_w_lp = ways_p > 1 ? $clog2(ways_p) : 1;
  localparam logic [1:0] e_reset = 2'd0, e_clear = 2'd1, e_run = 2'd2;

  logic [1:0] state;
  logic [idx_width_p-1:0] init_cnt;
  logic [ways_p-1:0] valid_r [sets_lp];
  logic [way_w_lp-1:0] vic_r [sets_lp];
  logic [tag_width_p-1:0] tag_r [sets_lp][ways_p];
  logic [cnt_width_p-1:0] spec_r [sets_lp][ways_p];
  logic [cnt_width_p-1:0] ns_r [sets_lp][ways_p];
  logic [cnt_width_p-1:0] trip_r [sets_lp][ways_p];
  logic [conf_width_p-1:0] conf_r [sets_lp][ways_p];

  logic is_run, r_hit, w_hit, inv_found, conflict, alloc, r_conf, r_exit, ns_max;
  logic [way_w_lp-1:0] r_way, w_way, inv_way, vic;
  logic [idx_width_p-1:0] r_idx, w_idx;
  logic [tag_width_p-1:0] r_tag, w_tag;
  logic [cnt_width_p-1:0] r_spec, w_ns, w_trip, ns_new, trip_new;
  logic [conf_width_p-1:0] w_conf, conf_new;
  logic unused;

  assign unused = ^{r_addr_i[1:0], r_addr_i[vaddr_width_p-1:2+idx_width_p+tag_width_p],
                    br_src_addr_i[1:0], br_src_addr_i[vaddr_width_p-1:2+idx_width_p+tag_width_p]};
  assign is_run = state == e_run;
  assign init_done_o = is_run;
  assign r_idx = r_addr_i[2+:idx_width_p];
  assign r_tag = r_addr_i[2+idx_width_p+:tag_width_p];
  assign w_idx = br_src_addr_i[2+:idx_width_p];
  assign w_tag = br_src_addr_i[2+idx_width_p+:tag_width_p];

  always_comb begin
    r_hit = 1'b0;
    r_way = '0;
    w_hit = 1'b0;
    w_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    for (int i = 0; i < ways_p; i++) begin
      if (valid_r[r_idx][i] && tag_r[r_idx][i] == r_tag) begin
        r_hit = 1'b1;
        r_way = way_w_lp'(i);
      end
      if (valid_r[w_idx][i] && tag_r[w_idx][i] == w_tag) begin
        w_hit = 1'b1;
        w_way = way_w_lp'(i);
      end
      if (!valid_r[w_idx][i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way = way_w_lp'(i);
      end
    end
  end

  assign r_spec = spec_r[r_idx][r_way];
  assign r_conf = &conf_r[r_idx][r_way];
  assign r_exit = r_conf & (r_spec == trip_r[r_idx][r_way]);
  // A non-replayed lookup owns its set this cycle; the resolution waits.
  assign conflict = r_v_i & ~r_retry_i & (r_idx == w_idx);
  assign w_yumi_o = is_run & w_v_i & ~conflict;
  assign w_ns = ns_r[w_idx][w_way];
  assign w_trip = trip_r[w_idx][w_way];
  assign w_conf = conf_r[w_idx][w_way];
  assign ns_max = &w_ns;
  assign ns_new = br_taken_i ? (ns_max ? w_ns : w_ns + 1'b1) : '0;
  assign trip_new = br_taken_i ? w_trip : w_ns;
  assign conf_new = br_taken_i ? (ns_max ? '0 : w_conf)
                  : (w_trip != '0 && w_ns == w_trip) ? (&w_conf ? w_conf : w_conf + 1'b1) : '0;
  assign alloc = ~w_hit & br_mispredict_i & ~br_taken_i;
  assign vic = inv_found ? inv_way : vic_r[w_idx];

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= e_reset;
      init_cnt <= '0;
      pred_v_o <= 1'b0;
      pred_conf_o <= 1'b0;
      pred_taken_o <= 1'b0;
    end else begin
      state <= state == e_reset ? e_clear
             : state == e_clear ? (&init_cnt ? e_run : e_clear)
             : state == e_run ? (flush_i ? e_clear : e_run) : e_reset;
      init_cnt <= state == e_clear ? init_cnt + 1'b1 : '0;
      pred_v_o <= is_run & r_v_i & r_hit;
      pred_conf_o <= is_run & r_v_i & r_hit & r_conf;
      pred_taken_o <= is_run & r_v_i & r_hit & ~r_exit;
    end

  always_ff @(posedge clk_i)
    if (state == e_clear) begin
      valid_r[init_cnt] <= '0;
      vic_r[init_cnt] <= '0;
      for (int i = 0; i < ways_p; i++) begin
        spec_r[init_cnt][i] <= '0;
        ns_r[init_cnt][i] <= '0;
        trip_r[init_cnt][i] <= '0;
        conf_r[init_cnt][i] <= '0;
      end
    end else if (is_run) begin
      if (r_v_i && r_hit && !r_retry_i)
        spec_r[r_idx][r_way] <= r_exit ? '0 : r_spec + 1'b1;
      if (w_yumi_o && w_hit) begin
        ns_r[w_idx][w_way] <= ns_new;
        trip_r[w_idx][w_way] <= trip_new;
        conf_r[w_idx][w_way] <= conf_new;
        if (br_mispredict_i)
          spec_r[w_idx][w_way] <= ns_new;
      end else if (w_yumi_o && alloc) begin
        valid_r[w_idx][vic] <= 1'b1;
        tag_r[w_idx][vic] <= w_tag;
        spec_r[w_idx][vic] <= '0;
        ns_r[w_idx][vic] <= '0;
        trip_r[w_idx][vic] <= '0;
        conf_r[w_idx][vic] <= '0;
        if (!inv_found)
          vic_r[w_idx] <= ways_p == 1 ? '0 : vic + 1'b1;
      end
    end
endmodule

// File: tb/tb_bp_fe_ltb_assoc.sv
// tb_bp_fe_ltb_assoc: directed checks of clear timing, trip learning, eviction,
// read/write conflict, replay, flush and asynchronous reset.
module tb_bp_fe_ltb_assoc;
  localparam int sets = 64;
  logic clk = 1'b0;
  logic rst_n, flush, init_done, r_v, r_retry, pred_v, pred_conf, pred_taken;
  logic w_v, br_taken, br_mis, w_yumi;
  logic [38:0] r_addr, w_addr;
  int total = 0, bad = 0, n;

  bp_fe_ltb_assoc dut (
    .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .init_done_o(init_done),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_retry_i(r_retry), .pred_v_o(pred_v),
    .pred_conf_o(pred_conf), .pred_taken_o(pred_taken), .w_v_i(w_v),
    .br_src_addr_i(w_addr), .br_taken_i(br_taken), .br_mispredict_i(br_mis),
    .w_yumi_o(w_yumi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] mk(input int t, input int i);
    return (39'(t) << 8) | (39'(i) << 2);
  endfunction

  task automatic lookup(input logic [38:0] a, input logic rt, input logic ev, input logic ec,
                        input logic et, input string tg);
    r_v = 1'b1;
    r_addr = a;
    r_retry = rt;
    @(negedge clk);
    r_v = 1'b0;
    r_retry = 1'b0;
    chk({tg, ".v"}, 32'(pred_v), 32'(ev));
    chk({tg, ".conf"}, 32'(pred_conf), 32'(ec));
    chk({tg, ".taken"}, 32'(pred_taken), 32'(et));
  endtask

  task automatic update(input logic [38:0] a, input logic tk, input logic mis, input string tg);
    w_v = 1'b1;
    w_addr = a;
    br_taken = tk;
    br_mis = mis;
    #1 chk({tg, ".yumi"}, 32'(w_yumi), 32'd1);
    @(negedge clk);
    w_v = 1'b0;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (!init_done && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000 $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [38:0] l, a, b, c;
    l = mk(7, 10);
    a = mk(1, 5);
    b = mk(2, 5);
    c = mk(3, 5);
    rst_n = 1'b0; flush = 1'b0; r_v = 1'b0; r_retry = 1'b0; r_addr = '0;
    w_v = 1'b1; w_addr = '0; br_taken = 1'b0; br_mis = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.init_done", 32'(init_done), 0);
    chk("rst.pred_v", 32'(pred_v), 0);
    chk("rst.yumi", 32'(w_yumi), 0);
    w_v = 1'b0;
    rst_n = 1'b1;
    wait_init(n);
    chk("rst.clear_len", 32'(n), sets + 1);
    lookup(l, 0, 0, 0, 0, "cold.l");
    lookup(a, 0, 0, 0, 0, "cold.a");
    // Trip-4 loop: allocate on the mispredicted exit, then four training instances
    update(l, 0, 1, "alloc.l");
    for (int k = 0; k < 4; k++) begin
      repeat (4) update(l, 1, 0, "train.t");
      update(l, 0, 0, "train.n");
    end
    for (int k = 0; k < 4; k++) lookup(l, 0, 1, 1, 1, "trip.iter");
    lookup(l, 0, 1, 1, 0, "trip.exit");
    for (int k = 0; k < 4; k++) lookup(l, 0, 1, 1, 1, "trip2.iter");
    lookup(l, 1, 1, 1, 0, "retry.exit");
    lookup(l, 0, 1, 1, 0, "retry.again");
    lookup(l, 0, 1, 1, 1, "retry.after");
    update(l, 1, 1, "repair1");
    update(l, 1, 1, "repair2");
    lookup(l, 0, 1, 1, 1, "repair.i3");
    lookup(l, 0, 1, 1, 1, "repair.i4");
    lookup(l, 0, 1, 1, 0, "repair.exit");
    update(a, 0, 1, "alloc.a");
    update(b, 0, 1, "alloc.b");
    update(b, 1, 0, "nohit.noalloc");
    lookup(a, 0, 1, 0, 1, "set.a");
    lookup(b, 0, 1, 0, 1, "set.b");
    update(c, 0, 1, "alloc.c");
    lookup(a, 0, 0, 0, 0, "evict0.a");
    lookup(b, 0, 1, 0, 1, "evict0.b");
    lookup(c, 0, 1, 0, 1, "evict0.c");
    update(a, 0, 1, "realloc.a");
    lookup(b, 0, 0, 0, 0, "evict1.b");
    lookup(a, 0, 1, 0, 1, "evict1.a");
    lookup(c, 0, 1, 0, 1, "evict1.c");
    lookup(mk(9, 5), 0, 0, 0, 0, "miss.notag");
    r_v = 1'b1; r_addr = a; r_retry = 1'b0;
    w_v = 1'b1; w_addr = c; br_taken = 1'b1; br_mis = 1'b0;
    #1 chk("conflict.yumi", 32'(w_yumi), 0);
    @(negedge clk);
    r_v = 1'b0;
    chk("conflict.pred_v", 32'(pred_v), 1);
    #1 chk("conflict.retry_yumi", 32'(w_yumi), 1);
    @(negedge clk);
    r_v = 1'b1; r_retry = 1'b1;
    #1 chk("replay.yumi", 32'(w_yumi), 1);
    @(negedge clk);
    r_v = 1'b0; r_retry = 1'b0; w_v = 1'b0;
    chk("replay.pred_v", 32'(pred_v), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.init_done", 32'(init_done), 0);
    wait_init(n);
    chk("flush.clear_len", 32'(n), sets);
    lookup(l, 0, 0, 0, 0, "flush.l");
    lookup(a, 0, 0, 0, 0, "flush.a");
    lookup(c, 0, 0, 0, 0, "flush.c");
    update(l, 0, 1, "alloc2.l");
    lookup(l, 0, 1, 0, 1, "alloc2.hit");
    r_v = 1'b1; r_addr = l;
    @(negedge clk);
    chk("arst.before", 32'(pred_v), 1);
    #2 rst_n = 1'b0;
    #1 chk("arst.pred_v", 32'(pred_v), 0);
    chk("arst.taken", 32'(pred_taken), 0);
    chk("arst.init_done", 32'(init_done), 0);
    r_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("arst.clear_len", 32'(n), sets + 1);
    lookup(l, 0, 0, 0, 0, "arst.l");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midclr.init_done", 32'(init_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("midclr.clear_len", 32'(n), sets + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
